// File: rtl/note_tone_gen_if.sv
// Note request channel from the sequencer to the tone generator.
// The master presents a note with valid; the generator raises ready only while idle.
interface note_tone_gen_if;
  logic        note_valid;
  logic        note_ready;
  logic [15:0] note_half_period;
  logic [15:0] note_duration_ms;

  modport master (
    output note_valid,
    output note_half_period,
    output note_duration_ms,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_half_period,
    input  note_duration_ms,
    output note_ready
  );
endinterface

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: plays one captured note, appends a GAP_MS silent gap, pulses note_done.
// First sound edge H cycles after accept; busy for (D+GAP_MS)*P cycles, ready only when idle.
module note_tone_gen #(
  parameter int unsigned GAP_MS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    ticks_per_milli,
  note_tone_gen_if.slave note,
  output logic           sound,
  output logic           playing,
  output logic           note_done
);

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_TONE = 2'd1;
  localparam logic [1:0]  ST_GAP  = 2'd2;
  localparam logic [16:0] GAP_LEN = 17'(GAP_MS);

  logic [1:0]  state_q, state_d;
  logic [15:0] half_q, half_d;
  logic [15:0] dur_q, dur_d;
  logic [15:0] tpm_q, tpm_d;
  logic [15:0] pre_q, pre_d;
  logic [15:0] ms_q, ms_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic        sound_q, sound_d;
  logic        done_q, done_d;

  logic        accept;
  logic        ms_tick;
  logic        half_wrap;
  logic        tone_end;
  logic        gap_end;
  logic [15:0] period;
  logic [16:0] ms_next;

  // ms_next is 17 bits wide so a duration of 65535 compares without wrapping.
  always_comb begin
    period    = (tpm_q == 16'd0) ? 16'd1 : tpm_q;
    ms_next   = {1'b0, ms_q} + 17'd1;
    accept    = note.note_valid && (state_q == ST_IDLE);
    ms_tick   = (state_q != ST_IDLE) && (pre_q == period - 16'd1);
    half_wrap = (half_q != 16'd0) && (hcnt_q == half_q - 16'd1);
    tone_end  = (state_q == ST_TONE) &&
                ((dur_q == 16'd0) || (ms_tick && (ms_next == {1'b0, dur_q})));
    gap_end   = (state_q == ST_GAP) && ms_tick && (ms_next == GAP_LEN);
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    dur_d   = dur_q;
    tpm_d   = tpm_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    hcnt_d  = hcnt_q;
    sound_d = sound_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          half_d  = note.note_half_period;
          dur_d   = note.note_duration_ms;
          tpm_d   = ticks_per_milli;
          pre_d   = 16'd0;
          ms_d    = 16'd0;
          hcnt_d  = 16'd0;
          sound_d = 1'b0;
          state_d = ST_TONE;
        end
      end

      ST_TONE: begin
        pre_d = ms_tick ? 16'd0 : pre_q + 16'd1;
        if (tone_end) begin
          // The tone is cut at the ms boundary whatever the square-wave phase.
          hcnt_d  = 16'd0;
          sound_d = 1'b0;
          if (GAP_MS > 0) begin
            ms_d    = 16'd0;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          if (ms_tick) begin
            ms_d = ms_next[15:0];
          end
          if (half_q == 16'd0) begin
            sound_d = 1'b0;
          end else if (half_wrap) begin
            hcnt_d  = 16'd0;
            sound_d = ~sound_q;
          end else begin
            hcnt_d = hcnt_q + 16'd1;
          end
        end
      end

      ST_GAP: begin
        pre_d   = ms_tick ? 16'd0 : pre_q + 16'd1;
        sound_d = 1'b0;
        if (gap_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (ms_tick) begin
          ms_d = ms_next[15:0];
        end
      end

      default: begin
        state_d = ST_IDLE;
        sound_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      half_q  <= 16'd0;
      dur_q   <= 16'd0;
      tpm_q   <= 16'd0;
      pre_q   <= 16'd0;
      ms_q    <= 16'd0;
      hcnt_q  <= 16'd0;
      sound_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      dur_q   <= dur_d;
      tpm_q   <= tpm_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      hcnt_q  <= hcnt_d;
      sound_q <= sound_d;
      done_q  <= done_d;
    end
  end

  assign note.note_ready = (state_q == ST_IDLE);
  assign playing         = (state_q != ST_IDLE);
  assign sound           = sound_q;
  assign note_done       = done_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Scoreboard bench: each note pushes its expected sound edges and note_done cycle; tasks pop and compare.
`timescale 1ns/1ps
module tb_note_tone_gen;

  typedef struct {
    bit          kind;  // 0 = sound change, 1 = note_done pulse
    int unsigned t;
    bit          val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tpm1, tpm0;
  logic        snd1, play1, done1;
  logic        snd0, play0, done0;
  int unsigned cyc = 0;
  int          passed = 0;
  int          total = 0;
  ev_t         exp_q[$];

  note_tone_gen_if if1();
  note_tone_gen_if if0();

  note_tone_gen #(.GAP_MS(1)) dut1 (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm1), .note(if1.slave),
    .sound(snd1), .playing(play1), .note_done(done1)
  );

  note_tone_gen #(.GAP_MS(0)) dut0 (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm0), .note(if0.slave),
    .sound(snd0), .playing(play0), .note_done(done0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected timeline of one note accepted at edge e0; events at or after cut are dropped.
  task automatic push_note(input int unsigned e0, p, h, d, g, cut);
    int unsigned pe, tend, td;
    bit s;
    ev_t ev;
    pe   = (p == 0) ? 1 : p;
    tend = (d == 0) ? e0 + 1 : e0 + d * pe;
    s    = 1'b0;
    if (h != 0 && d != 0) begin
      for (int unsigned t = e0 + h; t < tend; t += h) begin
        s = ~s;
        ev = '{kind: 1'b0, t: t, val: s};
        if (t < cut) exp_q.push_back(ev);
      end
    end
    if (s) begin
      ev = '{kind: 1'b0, t: tend, val: 1'b0};
      if (tend < cut) exp_q.push_back(ev);
    end
    if (d == 0) td = (g == 0) ? e0 + 1 : ((pe == 1) ? e0 + g + 1 : e0 + g * pe);
    else        td = e0 + (d + g) * pe;
    ev = '{kind: 1'b1, t: td, val: 1'b1};
    if (td < cut) exp_q.push_back(ev);
  endtask

  // Presents a note on dut1 when it is ready; returns with cyc == e0 at a falling edge.
  task automatic send1(input logic [15:0] p, h, d, output int unsigned e0);
    int n = 0;
    @(negedge clk);
    while (!if1.note_ready && n < 1000) begin @(negedge clk); n++; end
    tpm1 = p; if1.note_half_period = h; if1.note_duration_ms = d; if1.note_valid = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    if1.note_valid = 1'b0;
  endtask

  task automatic send0(input logic [15:0] p, h, d, output int unsigned e0);
    int n = 0;
    @(negedge clk);
    while (!if0.note_ready && n < 1000) begin @(negedge clk); n++; end
    tpm0 = p; if0.note_half_period = h; if0.note_duration_ms = d; if0.note_valid = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    if0.note_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({snd1, play1, done1, if1.note_ready} !== 4'b0001)
      $display("FAIL reset_g1: sound/playing/done/ready=%b required 0001", {snd1, play1, done1, if1.note_ready});
    else passed++;
    total++;
    if ({snd0, play0, done0, if0.note_ready} !== 4'b0001)
      $display("FAIL reset_g0: sound/playing/done/ready=%b required 0001", {snd0, play0, done0, if0.note_ready});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({snd1, play1, done1, if1.note_ready} !== 4'b0001)
      $display("FAIL idle_after_reset: sound/playing/done/ready=%b required 0001", {snd1, play1, done1, if1.note_ready});
    else passed++;
  endtask

  task automatic test_basic();
    int unsigned e0;
    ev_t ev;
    bit prev_s;
    send1(16'd10, 16'd3, 16'd2, e0);
    push_note(e0, 10, 3, 2, 1, 32'hFFFF_FFFF);
    total++;
    if (play1 !== 1'b1 || if1.note_ready !== 1'b0)
      $display("FAIL basic_accept: playing=%b ready=%b required 1 0", play1, if1.note_ready);
    else passed++;
    prev_s = snd1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (cyc == e0 + 29) begin
        total++;
        if (play1 !== 1'b1) $display("FAIL basic_playing_end: playing=%b required 1", play1);
        else passed++;
      end
      if (snd1 !== prev_s) begin
        total++; prev_s = snd1;
        if (exp_q.size() == 0) $display("FAIL basic_sound: unexpected sound=%b at cycle %0d", snd1, cyc);
        else begin
          ev = exp_q.pop_front();
          if (ev.kind !== 1'b0 || ev.t !== cyc || ev.val !== snd1)
            $display("FAIL basic_sound: sound=%b at cycle %0d, required kind=%0d val=%b at cycle %0d", snd1, cyc, ev.kind, ev.val, ev.t);
          else passed++;
        end
      end
      if (done1) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL basic_done: unexpected note_done at cycle %0d", cyc);
        else begin
          ev = exp_q.pop_front();
          if (ev.kind !== 1'b1 || ev.t !== cyc)
            $display("FAIL basic_done: note_done at cycle %0d, required kind=%0d at cycle %0d", cyc, ev.kind, ev.t);
          else passed++;
        end
      end
    end
    if (exp_q.size() != 0) begin
      total++; $display("FAIL basic_timeout: %0d events outstanding, required 0", exp_q.size()); exp_q.delete();
    end
    total++;
    if (play1 !== 1'b0 || if1.note_ready !== 1'b1)
      $display("FAIL basic_idle: playing=%b ready=%b required 0 1", play1, if1.note_ready);
    else passed++;
    @(negedge clk);
    total++;
    if (done1 !== 1'b0) $display("FAIL basic_done_width: note_done=%b on second idle cycle, required 0", done1);
    else passed++;
  endtask

  task automatic test_rest();
    int unsigned e0;
    ev_t ev;
    bit prev_s;
    send1(16'd4, 16'd0, 16'd3, e0);
    push_note(e0, 4, 0, 3, 1, 32'hFFFF_FFFF);
    prev_s = snd1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (snd1 !== prev_s) begin
        total++; prev_s = snd1;
        if (exp_q.size() == 0) $display("FAIL rest_sound: unexpected sound=%b at cycle %0d", snd1, cyc);
        else begin
          ev = exp_q.pop_front();
          if (ev.kind !== 1'b0 || ev.t !== cyc || ev.val !== snd1)
            $display("FAIL rest_sound: sound=%b at cycle %0d, required kind=%0d at cycle %0d", snd1, cyc, ev.kind, ev.t);
          else passed++;
        end
      end
      if (done1) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL rest_done: unexpected note_done at cycle %0d", cyc);
        else begin
          ev = exp_q.pop_front();
          if (ev.kind !== 1'b1 || ev.t !== cyc)
            $display("FAIL rest_done: note_done at cycle %0d, required kind=%0d at cycle %0d", cyc, ev.kind, ev.t);
          else passed++;
        end
      end
    end
    if (exp_q.size() != 0) begin
      total++; $display("FAIL rest_timeout: %0d events outstanding, required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_degenerate();
    int unsigned e0;
    ev_t ev;
    bit prev_s;
    send0(16'd0, 16'd1, 16'd4, e0);
    push_note(e0, 0, 1, 4, 0, 32'hFFFF_FFFF);
    prev_s = snd0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (snd0 !== prev_s) begin
        total++; prev_s = snd0;
        if (exp_q.size() == 0) $display("FAIL p0_sound: unexpected sound=%b at cycle %0d", snd0, cyc);
        else begin
          ev = exp_q.pop_front();
          if (ev.kind !== 1'b0 || ev.t !== cyc || ev.val !== snd0)
            $display("FAIL p0_sound: sound=%b at cycle %0d, required kind=%0d val=%b at cycle %0d", snd0, cyc, ev.kind, ev.val, ev.t);
          else passed++;
        end
      end
      if (done0) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL p0_done: unexpected note_done at cycle %0d", cyc);
        else begin
          ev = exp_q.pop_front();
          if (ev.kind !== 1'b1 || ev.t !== cyc)
            $display("FAIL p0_done: note_done at cycle %0d, required kind=%0d at cycle %0d", cyc, ev.kind, ev.t);
          else passed++;
        end
      end
    end
    if (exp_q.size() != 0) begin
      total++; $display("FAIL p0_timeout: %0d events outstanding, required 0", exp_q.size()); exp_q.delete();
    end
    // Zero duration with no gap: one TONE cycle, no toggle, done straight after.
    send0(16'd3, 16'd5, 16'd0, e0);
    total++;
    if (play0 !== 1'b1) $display("FAIL d0_accept: playing=%b required 1", play0);
    else passed++;
    @(negedge clk);
    total++;
    if (done0 !== 1'b1 || snd0 !== 1'b0 || play0 !== 1'b0)
      $display("FAIL d0_done: note_done=%b sound=%b playing=%b required 1 0 0", done0, snd0, play0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int unsigned ea, eb;
    int n;
    ev_t ev;
    bit prev_s;
    n = 0;
    @(negedge clk);
    while (!if1.note_ready && n < 1000) begin @(negedge clk); n++; end
    tpm1 = 16'd2; if1.note_half_period = 16'd1; if1.note_duration_ms = 16'd2; if1.note_valid = 1'b1;
    ea = cyc + 1;
    @(negedge clk);
    // Note B is presented while A plays; A must keep its captured values.
    tpm1 = 16'd3; if1.note_half_period = 16'd2; if1.note_duration_ms = 16'd1;
    eb = ea + 3 * 2 + 1;
    push_note(ea, 2, 1, 2, 1, 32'hFFFF_FFFF);
    push_note(eb, 3, 2, 1, 1, 32'hFFFF_FFFF);
    prev_s = snd1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (cyc == ea + 3) begin
        total++;
        if (if1.note_ready !== 1'b0) $display("FAIL b2b_busy: ready=%b while playing, required 0", if1.note_ready);
        else passed++;
      end
      if (cyc == eb) begin
        if1.note_valid = 1'b0;
        total++;
        if (play1 !== 1'b1) $display("FAIL b2b_accept_b: playing=%b at cycle %0d, required 1", play1, cyc);
        else passed++;
      end
      if (snd1 !== prev_s) begin
        total++; prev_s = snd1;
        if (exp_q.size() == 0) $display("FAIL b2b_sound: unexpected sound=%b at cycle %0d", snd1, cyc);
        else begin
          ev = exp_q.pop_front();
          if (ev.kind !== 1'b0 || ev.t !== cyc || ev.val !== snd1)
            $display("FAIL b2b_sound: sound=%b at cycle %0d, required kind=%0d val=%b at cycle %0d", snd1, cyc, ev.kind, ev.val, ev.t);
          else passed++;
        end
      end
      if (done1) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL b2b_done: unexpected note_done at cycle %0d", cyc);
        else begin
          ev = exp_q.pop_front();
          if (ev.kind !== 1'b1 || ev.t !== cyc)
            $display("FAIL b2b_done: note_done at cycle %0d, required kind=%0d at cycle %0d", cyc, ev.kind, ev.t);
          else passed++;
        end
      end
    end
    if1.note_valid = 1'b0;
    if (exp_q.size() != 0) begin
      total++; $display("FAIL b2b_timeout: %0d events outstanding, required 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int unsigned e0;
    int pulses;
    int n;
    ev_t ev;
    bit prev_s;
    send1(16'd10, 16'd3, 16'd2, e0);
    push_note(e0, 10, 3, 2, 1, e0 + 7);
    prev_s = snd1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (snd1 !== prev_s) begin
        total++; prev_s = snd1;
        if (exp_q.size() == 0) $display("FAIL rst_sound: unexpected sound=%b at cycle %0d", snd1, cyc);
        else begin
          ev = exp_q.pop_front();
          if (ev.kind !== 1'b0 || ev.t !== cyc || ev.val !== snd1)
            $display("FAIL rst_sound: sound=%b at cycle %0d, required val=%b at cycle %0d", snd1, cyc, ev.val, ev.t);
          else passed++;
        end
      end
    end
    total++;
    if (cyc !== e0 + 6 || exp_q.size() != 0) begin
      $display("FAIL rst_prefix: at cycle %0d with %0d events outstanding, required cycle %0d and 0", cyc, exp_q.size(), e0 + 6);
      exp_q.delete();
    end else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({snd1, if1.note_ready, play1, done1} !== 4'b0100)
      $display("FAIL rst_mid: sound/ready/playing/done=%b required 0100", {snd1, if1.note_ready, play1, done1});
    else passed++;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done1 === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) $display("FAIL rst_no_done: %0d note_done pulses after reset, required 0", pulses);
    else passed++;
    send1(16'd2, 16'd1, 16'd1, e0);
    total++;
    if (play1 !== 1'b1) $display("FAIL rst_fresh_accept: playing=%b required 1", play1);
    else passed++;
    n = 0;
    while (done1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (done1 !== 1'b1 || cyc !== e0 + 4)
      $display("FAIL rst_fresh_done: note_done=%b at cycle %0d, required 1 at cycle %0d", done1, cyc, e0 + 4);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    tpm1 = 16'd0; tpm0 = 16'd0;
    if1.note_valid = 1'b0; if1.note_half_period = 16'd0; if1.note_duration_ms = 16'd0;
    if0.note_valid = 1'b0; if0.note_half_period = 16'd0; if0.note_duration_ms = 16'd0;
    test_reset();
    test_basic();
    test_rest();
    test_degenerate();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
